// File: rtl/tlb_op_unit.sv
// tlb_op_unit
// Sequencer for the LoongArch TLB management instructions (TLBSRCH, TLBRD,
// TLBWR, TLBFILL, INVTLB). It sits between the MEM stage / CSR file and the
// TLB array. Each instruction walks IDLE -> EXEC -> DONE. The TLB ports are
// driven during EXEC, and the CSR results are returned with a one-cycle
// op_done pulse in DONE.
//
// Build option: define TLB_FILL_LFSR_EN to take the TLBFILL index from an
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1). Otherwise the index comes from a
// free-running modulo-NUM counter.

module tlb_op_unit #(
   parameter int NUM  = 16,
   parameter int IDXW = $clog2(NUM)
) (
   input  logic            clk,
   input  logic            resetn,

   input  logic            op_valid,
   output logic            op_ready,
   input  logic [2:0]      op_code,
   input  logic [4:0]      inv_op,
   input  logic [9:0]      inv_asid,
   input  logic [31:0]     inv_va,
   input  logic [88:0]     csr_entry,
   input  logic [IDXW-1:0] csr_index,
   input  logic [5:0]      csr_ecode,

   output logic [18:0]     tlb_s1_vppn,
   output logic            tlb_s1_va_bit12,
   output logic [9:0]      tlb_s1_asid,
   input  logic            tlb_s1_found,
   input  logic [IDXW-1:0] tlb_s1_findex,

   output logic            tlb_we,
   output logic [IDXW-1:0] tlb_w_index,
   output logic [88:0]     tlb_w_entry,

   output logic [IDXW-1:0] tlb_r_index,
   input  logic [88:0]     tlb_r_entry,

   output logic            tlb_invtlb_valid,
   output logic [4:0]      tlb_inv_op,

   output logic            op_done,
   output logic            op_ine,
   output logic            csr_idx_we,
   output logic            csr_ne_out,
   output logic            csr_entry_we,
   output logic [IDXW-1:0] csr_idx_out,
   output logic [88:0]     csr_entry_out
);

   // Sequencer states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Instruction encodings on op_code
   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

   // Highest INVTLB op value that the TLB understands
   localparam logic [4:0] INV_OP_MAX = 5'd6;

   // ESTAT.Ecode of a TLB refill exception
   localparam logic [5:0] ECODE_TLBR = 6'h3F;

   // Field positions inside the packed 89-bit entry
   localparam int E_BIT   = 88;
   localparam int VPPN_HI = 87;
   localparam int VPPN_LO = 69;
   localparam int ASID_HI = 62;
   localparam int ASID_LO = 53;

   logic [1:0]      state;
   logic            accept;
   logic            illegal_in;

   // Operands held for the duration of one instruction
   logic [2:0]      op_q;
   logic            ine_q;
   logic [4:0]      inv_op_q;
   logic [9:0]      inv_asid_q;
   logic [18:0]     inv_vppn_q;
   logic [88:0]     entry_q;
   logic [IDXW-1:0] index_q;
   logic            refill_q;
   logic [IDXW-1:0] fill_idx_q;

   // Source of the TLBFILL victim index
   logic [IDXW-1:0] fill_idx;

   // Entry as it is written into the TLB (e forced during refill)
   logic [88:0]     wr_entry;

   // Results captured at the end of EXEC and presented in DONE
   logic            res_ine;
   logic            res_idx_we;
   logic            res_ne;
   logic            res_entry_we;
   logic [IDXW-1:0] res_idx;
   logic [88:0]     res_entry;

   // The low 13 bits of the INVTLB address never reach the TLB
   logic            unused_inv_va_lo;
   assign unused_inv_va_lo = ^inv_va[12:0];

   assign op_ready   = (state == ST_IDLE);
   assign accept     = op_valid && op_ready;
   assign illegal_in = (op_code > OP_INV) ||
                       ((op_code == OP_INV) && (inv_op > INV_OP_MAX));
   assign wr_entry   = {entry_q[E_BIT] | refill_q, entry_q[E_BIT-1:0]};

`ifdef TLB_FILL_LFSR_EN
   logic [7:0] fill_lfsr;

   // Advance the fill LFSR every cycle so the victim choice looks random
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fill_lfsr <= 8'h01;
      end else begin
         fill_lfsr <= {fill_lfsr[6:0],
                       fill_lfsr[7] ^ fill_lfsr[5] ^ fill_lfsr[4] ^ fill_lfsr[3]};
      end
   end

   assign fill_idx = fill_lfsr[IDXW-1:0];
`else
   logic [IDXW-1:0] fill_cnt;

   // Free-running victim counter; NUM is a power of two, so it wraps naturally
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fill_cnt <= '0;
      end else begin
         fill_cnt <= fill_cnt + IDXW'(1);
      end
   end

   assign fill_idx = fill_cnt;
`endif

   // IDLE -> EXEC -> DONE sequencing; every instruction takes the same path
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (accept) state <= ST_EXEC;
            ST_EXEC: state <= ST_DONE;
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Capture all operands at acceptance so MEM/CSR may move on immediately
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_q       <= '0;
         ine_q      <= 1'b0;
         inv_op_q   <= '0;
         inv_asid_q <= '0;
         inv_vppn_q <= '0;
         entry_q    <= '0;
         index_q    <= '0;
         refill_q   <= 1'b0;
         fill_idx_q <= '0;
      end else if (accept) begin
         op_q       <= op_code;
         ine_q      <= illegal_in;
         inv_op_q   <= inv_op;
         inv_asid_q <= inv_asid;
         inv_vppn_q <= inv_va[31:13];
         entry_q    <= csr_entry;
         index_q    <= csr_index;
         refill_q   <= (csr_ecode == ECODE_TLBR);
         fill_idx_q <= fill_idx;
      end
   end

   // Drive the TLB ports only while executing a legal instruction
   always_comb begin
      tlb_s1_vppn      = '0;
      tlb_s1_va_bit12  = 1'b0;
      tlb_s1_asid      = '0;
      tlb_we           = 1'b0;
      tlb_w_index      = '0;
      tlb_w_entry      = '0;
      tlb_r_index      = '0;
      tlb_invtlb_valid = 1'b0;
      tlb_inv_op       = '0;
      if ((state == ST_EXEC) && !ine_q) begin
         case (op_q)
            OP_SRCH: begin
               tlb_s1_vppn = entry_q[VPPN_HI:VPPN_LO];
               tlb_s1_asid = entry_q[ASID_HI:ASID_LO];
            end
            OP_RD: begin
               tlb_r_index = index_q;
            end
            OP_WR: begin
               tlb_we      = 1'b1;
               tlb_w_index = index_q;
               tlb_w_entry = wr_entry;
            end
            OP_FILL: begin
               tlb_we      = 1'b1;
               tlb_w_index = fill_idx_q;
               tlb_w_entry = wr_entry;
            end
            OP_INV: begin
               tlb_invtlb_valid = 1'b1;
               tlb_inv_op       = inv_op_q;
               tlb_s1_vppn      = inv_vppn_q;
               tlb_s1_asid      = inv_asid_q;
            end
            default: begin
               tlb_we = 1'b0;
            end
         endcase
      end
   end

   // Sample the TLB answers at the end of EXEC and form the CSR update
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         res_ine      <= 1'b0;
         res_idx_we   <= 1'b0;
         res_ne       <= 1'b0;
         res_entry_we <= 1'b0;
         res_idx      <= '0;
         res_entry    <= '0;
      end else if (state == ST_EXEC) begin
         res_ine      <= ine_q;
         res_idx_we   <= 1'b0;
         res_ne       <= 1'b0;
         res_entry_we <= 1'b0;
         res_idx      <= '0;
         res_entry    <= '0;
         if (!ine_q) begin
            case (op_q)
               OP_SRCH: begin
                  if (tlb_s1_found) begin
                     res_idx_we <= 1'b1;
                     res_idx    <= tlb_s1_findex;
                  end else begin
                     res_ne     <= 1'b1;
                  end
               end
               OP_RD: begin
                  res_entry_we <= 1'b1;
                  if (tlb_r_entry[E_BIT]) begin
                     res_entry <= tlb_r_entry;
                  end else begin
                     res_ne    <= 1'b1;
                  end
               end
               default: begin
                  res_idx_we <= 1'b0;
               end
            endcase
         end
      end
   end

   // Results are visible only during the op_done pulse
   assign op_done       = (state == ST_DONE);
   assign op_ine        = op_done & res_ine;
   assign csr_idx_we    = op_done & res_idx_we;
   assign csr_ne_out    = op_done & res_ne;
   assign csr_entry_we  = op_done & res_entry_we;
   assign csr_idx_out   = op_done ? res_idx   : '0;
   assign csr_entry_out = op_done ? res_entry : '0;

endmodule

// File: tb/tb_tlb_op_unit.sv
// tb_tlb_op_unit
// Directed bench for tlb_op_unit. A transaction-level model predicts every
// output for every cycle from the instruction rules, and a compare process
// checks the DUT against it on each falling edge. The directed sequence also
// pins literal values. Honours TLB_FILL_LFSR_EN for the fill index source.

module tb_tlb_op_unit;

   localparam int NUM  = 16;
   localparam int IDXW = 4;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic            op_valid = 1'b0;
   logic            op_ready;
   logic [2:0]      op_code = '0;
   logic [4:0]      inv_op = '0;
   logic [9:0]      inv_asid = '0;
   logic [31:0]     inv_va = '0;
   logic [88:0]     csr_entry = '0;
   logic [IDXW-1:0] csr_index = '0;
   logic [5:0]      csr_ecode = '0;
   logic [18:0]     tlb_s1_vppn;
   logic            tlb_s1_va_bit12;
   logic [9:0]      tlb_s1_asid;
   logic            tlb_s1_found = 1'b0;
   logic [IDXW-1:0] tlb_s1_findex = '0;
   logic            tlb_we;
   logic [IDXW-1:0] tlb_w_index;
   logic [88:0]     tlb_w_entry;
   logic [IDXW-1:0] tlb_r_index;
   logic [88:0]     tlb_r_entry = '0;
   logic            tlb_invtlb_valid;
   logic [4:0]      tlb_inv_op;
   logic            op_done;
   logic            op_ine;
   logic            csr_idx_we;
   logic            csr_ne_out;
   logic            csr_entry_we;
   logic [IDXW-1:0] csr_idx_out;
   logic [88:0]     csr_entry_out;

   int nChecks = 0;
   int nFails  = 0;

   tlb_op_unit #(.NUM(NUM), .IDXW(IDXW)) dut (
      .clk(clk), .resetn(resetn),
      .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
      .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
      .csr_entry(csr_entry), .csr_index(csr_index), .csr_ecode(csr_ecode),
      .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_va_bit12(tlb_s1_va_bit12),
      .tlb_s1_asid(tlb_s1_asid), .tlb_s1_found(tlb_s1_found),
      .tlb_s1_findex(tlb_s1_findex),
      .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
      .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
      .tlb_invtlb_valid(tlb_invtlb_valid), .tlb_inv_op(tlb_inv_op),
      .op_done(op_done), .op_ine(op_ine), .csr_idx_we(csr_idx_we),
      .csr_ne_out(csr_ne_out), .csr_entry_we(csr_entry_we),
      .csr_idx_out(csr_idx_out), .csr_entry_out(csr_entry_out)
   );

   // Free-running 10-time-unit clock
   initial forever #5 clk = ~clk;

   // Everything the DUT shows during one cycle
   typedef struct packed {
      logic            ready;
      logic [18:0]     s1Vppn;
      logic            s1Bit12;
      logic [9:0]      s1Asid;
      logic            we;
      logic [IDXW-1:0] wIndex;
      logic [88:0]     wEntry;
      logic [IDXW-1:0] rIndex;
      logic            invValid;
      logic [4:0]      invOp;
      logic            done;
      logic            ine;
      logic            idxWe;
      logic            ne;
      logic            entryWe;
      logic [IDXW-1:0] idxOut;
      logic [88:0]     entryOut;
   } expT;

   expT slots[8];
   int  cyc = 0;

   function automatic expT idleExp();
      expT e;
      e = '0;
      e.ready = 1'b1;
      return e;
   endfunction

   function automatic logic [88:0] mkEntry(input logic e, input logic [18:0] vppn,
                                           input logic [9:0] asid, input logic [51:0] lo);
      return {e, vppn, 6'd12, asid, 1'b0, lo};
   endfunction

   task automatic checkOutput(input string name, input logic [88:0] act, input logic [88:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: on each accepted instruction, schedule the EXEC and DONE cycles
   initial begin
      int   fc;
      logic [7:0] lfsrM;
      int   fillIdx;
      expT  ex;
      expT  dn;
      logic illegal;
      fc = 0;
      lfsrM = 8'h01;
      for (int i = 0; i < 8; i++) slots[i] = idleExp();
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) begin
            for (int i = 0; i < 8; i++) slots[i] = idleExp();
            fc = 0;
            lfsrM = 8'h01;
         end else begin
`ifdef TLB_FILL_LFSR_EN
            fillIdx = int'(lfsrM) % NUM;
`else
            fillIdx = fc;
`endif
            if (op_valid && slots[cyc % 8].ready) begin
               ex = '0;
               dn = '0;
               dn.done = 1'b1;
               illegal = (op_code > 3'd4) || (op_code == 3'd4 && inv_op > 5'd6);
               if (illegal) begin
                  dn.ine = 1'b1;
               end else begin
                  case (op_code)
                     3'd0: begin
                        ex.s1Vppn = csr_entry[87:69];
                        ex.s1Asid = csr_entry[62:53];
                        if (tlb_s1_found) begin
                           dn.idxWe  = 1'b1;
                           dn.idxOut = tlb_s1_findex;
                        end else begin
                           dn.ne = 1'b1;
                        end
                     end
                     3'd1: begin
                        ex.rIndex  = csr_index;
                        dn.entryWe = 1'b1;
                        if (tlb_r_entry[88]) dn.entryOut = tlb_r_entry;
                        else dn.ne = 1'b1;
                     end
                     3'd2, 3'd3: begin
                        ex.we     = 1'b1;
                        ex.wIndex = (op_code == 3'd2) ? csr_index : IDXW'(fillIdx);
                        ex.wEntry = csr_entry;
                        if (csr_ecode == 6'h3F) ex.wEntry[88] = 1'b1;
                     end
                     default: begin
                        ex.invValid = 1'b1;
                        ex.invOp    = inv_op;
                        ex.s1Vppn   = inv_va[31:13];
                        ex.s1Asid   = inv_asid;
                     end
                  endcase
               end
               slots[(cyc + 1) % 8] = ex;
               slots[(cyc + 2) % 8] = dn;
            end
            slots[cyc % 8] = idleExp();
            cyc++;
            fc = (fc + 1) % NUM;
            lfsrM = {lfsrM[6:0], lfsrM[7] ^ lfsrM[5] ^ lfsrM[4] ^ lfsrM[3]};
         end
      end
   end

   // Compare every DUT output against the model on each falling edge
   initial begin
      expT e;
      forever begin
         @(negedge clk);
         e = slots[cyc % 8];
         checkOutput("op_ready",     89'(op_ready),         89'(e.ready));
         checkOutput("s1_vppn",      89'(tlb_s1_vppn),      89'(e.s1Vppn));
         checkOutput("s1_va_bit12",  89'(tlb_s1_va_bit12),  89'(e.s1Bit12));
         checkOutput("s1_asid",      89'(tlb_s1_asid),      89'(e.s1Asid));
         checkOutput("tlb_we",       89'(tlb_we),           89'(e.we));
         checkOutput("w_index",      89'(tlb_w_index),      89'(e.wIndex));
         checkOutput("w_entry",      tlb_w_entry,           e.wEntry);
         checkOutput("r_index",      89'(tlb_r_index),      89'(e.rIndex));
         checkOutput("invtlb_valid", 89'(tlb_invtlb_valid), 89'(e.invValid));
         checkOutput("inv_op",       89'(tlb_inv_op),       89'(e.invOp));
         checkOutput("op_done",      89'(op_done),          89'(e.done));
         checkOutput("op_ine",       89'(op_ine),           89'(e.ine));
         checkOutput("idx_we",       89'(csr_idx_we),       89'(e.idxWe));
         checkOutput("ne_out",       89'(csr_ne_out),       89'(e.ne));
         checkOutput("entry_we",     89'(csr_entry_we),     89'(e.entryWe));
         checkOutput("idx_out",      89'(csr_idx_out),      89'(e.idxOut));
         checkOutput("entry_out",    csr_entry_out,         e.entryOut);
      end
   end

   // Present one instruction for one cycle and return one unit after acceptance
   task automatic applyStimulus(input logic [2:0] code, input logic [88:0] entry,
                                input logic [IDXW-1:0] index, input logic [5:0] ecode,
                                input logic [4:0] invOpV, input logic [9:0] invAsidV,
                                input logic [31:0] invVaV, input logic foundV,
                                input logic [IDXW-1:0] findexV, input logic [88:0] rEntryV);
      op_code       = code;
      csr_entry     = entry;
      csr_index     = index;
      csr_ecode     = ecode;
      inv_op        = invOpV;
      inv_asid      = invAsidV;
      inv_va        = invVaV;
      tlb_s1_found  = foundV;
      tlb_s1_findex = findexV;
      tlb_r_entry   = rEntryV;
      op_valid      = 1'b1;
      @(posedge clk);
      #1;
      op_valid      = 1'b0;
   endtask

   // Directed sequence with literal expectations
   initial begin
      logic [88:0] wrEntry;
      logic [88:0] rdEntry;
      logic [88:0] fillEntry;
      wrEntry   = mkEntry(1'b1, 19'h12345, 10'h007, 52'h0_1234_5678_9ABC);
      rdEntry   = mkEntry(1'b1, 19'h7ABCD, 10'h155, 52'hF_0000_1234_5678);
      fillEntry = mkEntry(1'b0, 19'h00ABC, 10'h003, 52'h0_0000_0000_0001);

      resetn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_op_done", 89'(op_done), 89'(1'b0));
      checkOutput("rst_tlb_we",  89'(tlb_we),  89'(1'b0));
      @(posedge clk);
      #1 resetn = 1'b1;

      // FILL accepted at the sixth edge after release: counter value 5
      repeat (5) @(posedge clk);
      #1;
      applyStimulus(3'd3, fillEntry, 4'd0, 6'h3F, 5'd0, 10'd0, 32'd0, 1'b0, 4'd0, 89'd0);
      @(negedge clk);
      checkOutput("fill_we",      89'(tlb_we), 89'(1'b1));
      checkOutput("fill_e_force", tlb_w_entry, mkEntry(1'b1, 19'h00ABC, 10'h003, 52'h1));
`ifndef TLB_FILL_LFSR_EN
      checkOutput("fill_w_index", 89'(tlb_w_index), 89'(4'd5));
`endif
      @(negedge clk);
      checkOutput("fill_done", 89'(op_done), 89'(1'b1));
      @(posedge clk); #1;

      // WR index 3: one-cycle write, done two cycles after accept
      applyStimulus(3'd2, wrEntry, 4'd3, 6'h00, 5'd0, 10'd0, 32'd0, 1'b0, 4'd0, 89'd0);
      @(negedge clk);
      checkOutput("wr_we",      89'(tlb_we),      89'(1'b1));
      checkOutput("wr_w_index", 89'(tlb_w_index), 89'(4'd3));
      checkOutput("wr_w_entry", tlb_w_entry,      wrEntry);
      checkOutput("wr_exec_done", 89'(op_done),   89'(1'b0));
      @(negedge clk);
      checkOutput("wr_done",    89'(op_done), 89'(1'b1));
      checkOutput("wr_we_off",  89'(tlb_we),  89'(1'b0));
      @(posedge clk); #1;

      // SRCH hit at index 3
      applyStimulus(3'd0, wrEntry, 4'd0, 6'h00, 5'd0, 10'd0, 32'd0, 1'b1, 4'd3, 89'd0);
      @(negedge clk);
      checkOutput("srch_vppn", 89'(tlb_s1_vppn), 89'(19'h12345));
      checkOutput("srch_asid", 89'(tlb_s1_asid), 89'(10'h007));
      @(negedge clk);
      checkOutput("srch_idx_we", 89'(csr_idx_we),  89'(1'b1));
      checkOutput("srch_idx",    89'(csr_idx_out), 89'(4'd3));
      checkOutput("srch_ne",     89'(csr_ne_out),  89'(1'b0));
      @(posedge clk); #1;

      // SRCH miss
      applyStimulus(3'd0, wrEntry, 4'd0, 6'h00, 5'd0, 10'd0, 32'd0, 1'b0, 4'd9, 89'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("miss_idx_we", 89'(csr_idx_we), 89'(1'b0));
      checkOutput("miss_ne",     89'(csr_ne_out), 89'(1'b1));
      @(posedge clk); #1;

      // RD of an invalid entry
      applyStimulus(3'd1, 89'd0, 4'd9, 6'h00, 5'd0, 10'd0, 32'd0, 1'b0, 4'd0,
                    mkEntry(1'b0, 19'h55555, 10'h2AA, 52'hA_BCDE_F012_3456));
      @(negedge clk);
      checkOutput("rd0_r_index", 89'(tlb_r_index), 89'(4'd9));
      @(negedge clk);
      checkOutput("rd0_entry_we", 89'(csr_entry_we), 89'(1'b1));
      checkOutput("rd0_entry",    csr_entry_out,     89'd0);
      checkOutput("rd0_ne",       89'(csr_ne_out),   89'(1'b1));
      @(posedge clk); #1;

      // RD of a valid entry
      applyStimulus(3'd1, 89'd0, 4'd15, 6'h00, 5'd0, 10'd0, 32'd0, 1'b0, 4'd0, rdEntry);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rd1_entry", csr_entry_out,   rdEntry);
      checkOutput("rd1_ne",    89'(csr_ne_out), 89'(1'b0));
      @(posedge clk); #1;

      // INVTLB op 5
      applyStimulus(3'd4, 89'd0, 4'd0, 6'h00, 5'd5, 10'h007, 32'h8000_2000, 1'b0, 4'd0, 89'd0);
      @(negedge clk);
      checkOutput("inv_valid", 89'(tlb_invtlb_valid), 89'(1'b1));
      checkOutput("inv_opv",   89'(tlb_inv_op),       89'(5'd5));
      checkOutput("inv_vppn",  89'(tlb_s1_vppn),      89'(19'h40001));
      checkOutput("inv_asid",  89'(tlb_s1_asid),      89'(10'h007));
      @(negedge clk);
      checkOutput("inv_valid_off", 89'(tlb_invtlb_valid), 89'(1'b0));
      checkOutput("inv_ine",       89'(op_ine),           89'(1'b0));
      @(posedge clk); #1;

      // INVTLB op 7 is illegal
      applyStimulus(3'd4, 89'd0, 4'd0, 6'h00, 5'd7, 10'h007, 32'h8000_2000, 1'b0, 4'd0, 89'd0);
      @(negedge clk);
      checkOutput("inv7_valid", 89'(tlb_invtlb_valid), 89'(1'b0));
      @(negedge clk);
      checkOutput("inv7_ine", 89'(op_ine), 89'(1'b1));
      @(posedge clk); #1;

      // Undefined op_code 6 is illegal
      applyStimulus(3'd6, wrEntry, 4'd3, 6'h3F, 5'd0, 10'd0, 32'd0, 1'b1, 4'd3, rdEntry);
      @(negedge clk);
      checkOutput("op6_we", 89'(tlb_we), 89'(1'b0));
      @(negedge clk);
      checkOutput("op6_ine", 89'(op_ine), 89'(1'b1));
      @(posedge clk); #1;

      // WR to the last index during refill forces e
      applyStimulus(3'd2, fillEntry, 4'd15, 6'h3F, 5'd0, 10'd0, 32'd0, 1'b0, 4'd0, 89'd0);
      @(negedge clk);
      checkOutput("wr15_index", 89'(tlb_w_index), 89'(4'd15));
      checkOutput("wr15_e",     89'(tlb_w_entry[88]), 89'(1'b1));
      @(negedge clk);
      @(posedge clk); #1;

      // Reset in the middle of a WR abandons the write
      applyStimulus(3'd2, wrEntry, 4'd6, 6'h00, 5'd0, 10'd0, 32'd0, 1'b0, 4'd0, 89'd0);
      #1 resetn = 1'b0;
      @(negedge clk);
      checkOutput("abort_we",   89'(tlb_we),  89'(1'b0));
      checkOutput("abort_done", 89'(op_done), 89'(1'b0));
      @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_ready", 89'(op_ready), 89'(1'b1));
      checkOutput("post_rst_done",  89'(op_done),  89'(1'b0));
      checkOutput("post_rst_we",    89'(tlb_we),   89'(1'b0));
      @(posedge clk); #1;

      // Recovery: an ordinary SRCH after reset
      applyStimulus(3'd0, wrEntry, 4'd0, 6'h00, 5'd0, 10'd0, 32'd0, 1'b1, 4'd12, 89'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rec_idx", 89'(csr_idx_out), 89'(4'd12));
      @(posedge clk); #1;

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/tlb_op_unit.md
Name: tlb_op_unit

Overview:
- Sequencer that executes LoongArch TLB management instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) against the TLB array.
- Sits between the MEM stage / CSR file and the TLB.
- Drives the TLB's search port 1, write port, read index and invalidate inputs.
- Returns CSR update results to the CSR file through a one-shot done/valid handshake.

Parameters:
NUM, 16, number of TLB entries (power of two, 4..256)
IDXW, $clog2(NUM), index width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
op_valid  in  1  instruction request from MEM stage
op_ready  out  1  unit can accept a request (IDLE only)
op_code  in  3  0=SRCH 1=RD 2=WR 3=FILL 4=INV; others illegal
inv_op  in  5  INVTLB op field
inv_asid  in  10  rj[9:0] for INVTLB
inv_va  in  32  rk for INVTLB
csr_entry  in  89  packed {e,vppn,ps,asid,g,ppn0,plv0,mat0,d0,v0,ppn1,plv1,mat1,d1,v1} from TLBEHI/TLBIDX/TLBELO0/1/ASID; e = ~TLBIDX.NE
csr_index  in  IDXW  TLBIDX.Index
csr_ecode  in  6  ESTAT.Ecode
tlb_s1_vppn  out  19  search vppn
tlb_s1_va_bit12  out  1  search va[12]
tlb_s1_asid  out  10  search asid
tlb_s1_found  in  1  search hit
tlb_s1_findex  in  IDXW  hit index
tlb_we  out  1  TLB write strobe
tlb_w_index  out  IDXW  write index
tlb_w_entry  out  89  packed write entry
tlb_r_index  out  IDXW  read index
tlb_r_entry  in  89  packed read entry
tlb_invtlb_valid  out  1  invalidate strobe
tlb_inv_op  out  5  invalidate op
op_done  out  1  one-cycle completion pulse
op_ine  out  1  with op_done: illegal op (INV op>6 or op_code>4)
csr_idx_we  out  1  with op_done: write TLBIDX.Index
csr_ne_out  out  1  with op_done: TLBIDX.NE value (always written on SRCH/RD)
csr_entry_we  out  1  with op_done: write TLBEHI/ELO0/ELO1/ASID/PS from csr_entry_out
csr_idx_out  out  IDXW  index result
csr_entry_out  out  89  read-back entry (e bit unused)

Behaviour:
- Reset (async, resetn=0): state=IDLE; op_ready=1 after release; all other outputs 0; fill counter=0; an in-flight op is abandoned, with no TLB write or invtlb pulse.
- FSM IDLE/EXEC/DONE. Handshake: accept when op_valid&op_ready; operands are registered at acceptance; op_ready=0 until the cycle after op_done.
- EXEC (1 cycle):
  - SRCH: s1 ports = registered csr_entry vppn, csr_entry asid, va_bit12=0; tlb_found/findex sampled at end of EXEC.
  - RD: tlb_r_index = csr_index; tlb_r_entry sampled at end of EXEC.
  - WR: tlb_we=1, w_index=csr_index.
  - FILL: tlb_we=1, w_index=fill index captured at acceptance.
  - WR/FILL entry: w_entry = csr_entry, except e is forced to 1 when csr_ecode==6'h3F (TLB refill).
  - INV: if inv_op<=6: tlb_invtlb_valid=1, tlb_inv_op=inv_op, s1 vppn=inv_va[31:13], s1 asid=inv_asid.
- DONE (1 cycle): op_done=1 with result qualifiers:
  - SRCH hit: csr_idx_we=1, idx_out=findex, ne_out=0, entry_we=0.
  - SRCH miss: idx_we=0, ne_out=1, entry_we=0.
  - RD, e=1: entry_we=1, entry_out=read entry, ne_out=0.
  - RD, e=0: entry_we=1, entry_out=0, ne_out=1.
  - WR/FILL/INV: idx_we=0, entry_we=0.
  - Illegal op: op_ine=1; EXEC asserts no strobes.
- Latency: accept -> op_done = 2 cycles, for all ops. Back-to-back throughput: one op every 3 cycles.
- Write visibility: a WR followed immediately by SRCH/RD sees the new entry, because the write commits at the end of EXEC.
- Fill counter: free-running, increments every cycle, wraps NUM-1 -> 0.
- All result outputs are 0 whenever op_done=0.

Optional Feature:
TLB_FILL_LFSR_EN:
- Defined: the fill index comes from an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1. Seed 8'h01 on reset. Advances every cycle; index = lfsr[IDXW-1:0].
- Undefined: the free-running modulo-NUM counter is used.

Test Plan:
- Reset, then WR with csr_index=3, entry vppn=19'h12345, e=1 -> tlb_we pulse 1 cycle, w_index=3; op_done exactly 2 cycles after accept.
- SRCH with vppn=19'h12345 and TLB returning found=1, findex=3 -> op_done, csr_idx_we=1, idx_out=3, ne_out=0.
- SRCH with TLB returning found=0 -> idx_we=0, ne_out=1.
- RD of an entry with e=0 -> entry_we=1, entry_out=0, ne_out=1.
- RD of an entry with e=1 -> entry_out equals tlb_r_entry.
- FILL with csr_ecode=6'h3F and csr_entry e=0 -> w_entry e=1.
- FILL (counter build) accepted with counter=5 -> w_index=5.
- INV with inv_op=5, inv_asid=10'h7, inv_va=32'h8000_2000 -> invtlb_valid 1 cycle, s1_vppn=19'h40001, s1_asid=7.
- INV with inv_op=7 -> no invtlb pulse, op_ine=1.
- resetn dropped during EXEC of WR -> no tlb_we; after release, op_ready=1 and all outputs 0.
